spi_transfer_arbiter: RTL

Round-robin arbiter and sequencer that shares one 32-bit SPI transfer core (four bytes per transaction, single `go_transfer` start strobe, `data_pack_ready` completion level) between up to eight requesters. It sits between the Avalon-side requesters and the SPI core. It selects one request, launches the transaction with a single-cycle start strobe, and holds write data stable until completion. It then returns the 32-bit read word to the winning requester, and recovers with an error flag if the core never completes.

---
 rtl/spi_transfer_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_transfer_arbiter.sv
// Round-robin arbiter that shares one 32-bit SPI transfer core between N_REQ requesters,
// launching each transaction with a one-cycle strobe and abandoning it with err after a timeout.
module spi_transfer_arbiter #(
   parameter int N_REQ          = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [32*N_REQ-1:0]   wdata,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic                  err,
   output logic [31:0]           rdata,
   output logic                  busy,
   output logic [IDX_W-1:0]      owner_idx,
   output logic                  go_transfer,
   output logic [31:0]           spi_data_write,
   input  logic [31:0]           data_read_to_avalon,
   input  logic                  data_pack_ready
);

   typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

   localparam int                CNT_W    = 16;
   localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

   state_t             state, state_d;
   logic [IDX_W-1:0]   ptr, ptr_d;
   logic [CNT_W-1:0]   count, count_d;
   logic               ready_q;
   logic               ready_edge;

   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   cand;
   logic               found;

   logic [N_REQ-1:0]   gnt_d, done_d;
   logic               err_d, busy_d, go_d;
   logic [31:0]        rdata_d, wr_d;
   logic [IDX_W-1:0]   owner_d;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   assign ready_edge = data_pack_ready & ~ready_q;

   // First set request scanning upward from the pointer, wrapping at N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      count_d = count;
      gnt_d   = gnt;
      done_d  = '0;
      err_d   = 1'b0;
      rdata_d = rdata;
      busy_d  = busy;
      owner_d = owner_idx;
      go_d    = 1'b0;
      wr_d    = spi_data_write;
      case (state)
         IDLE: begin
            if (found) begin
               owner_d = pick;
               gnt_d   = N_REQ'(1) << pick;
               wr_d    = wdata[32*pick +: 32];
               go_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            count_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            count_d = count + CNT_W'(1);
            // A ready edge on the terminal count still wins over the timeout.
            if (ready_edge) begin
               rdata_d = data_read_to_avalon;
               done_d  = gnt;
               ptr_d   = wrap_inc(owner_idx);
               state_d = GAP;
            end else if (count == TERMINAL) begin
               rdata_d = '0;
               done_d  = gnt;
               err_d   = 1'b1;
               ptr_d   = wrap_inc(owner_idx);
               state_d = GAP;
            end
         end
         GAP: begin
            if (!data_pack_ready) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= '0;
         count          <= '0;
         ready_q        <= 1'b0;
         gnt            <= '0;
         done           <= '0;
         err            <= 1'b0;
         rdata          <= '0;
         busy           <= 1'b0;
         owner_idx      <= '0;
         go_transfer    <= 1'b0;
         spi_data_write <= '0;
      end else begin
         state          <= state_d;
         ptr            <= ptr_d;
         count          <= count_d;
         ready_q        <= data_pack_ready;
         gnt            <= gnt_d;
         done           <= done_d;
         err            <= err_d;
         rdata          <= rdata_d;
         busy           <= busy_d;
         owner_idx      <= owner_d;
         go_transfer    <= go_d;
         spi_data_write <= wr_d;
      end
   end

endmodule
